vga_scan_gen: RTL and testbench

//   Raster timing source for the VGA display path. Scans the pixel position
//   (DrawX/DrawY) and produces the display-enable (blank), hs, vs and

---
 rtl/vga_scan_gen.sv | 108 ++++++++++
 tb/tb_vga_scan_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA raster scan counters with blank, delayed hs/vs and line/frame strobes
module vga_scan_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit thresholds so a 1024-wide raster cannot overflow the sync-end bound
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    generate
        if (H_TOTAL > 1024) begin : g_h_total_err
            $error("vga_scan_gen: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > 1024) begin : g_v_total_err
            $error("vga_scan_gen: V_TOTAL exceeds 1024");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_delay_err
            $error("vga_scan_gen: SYNC_DELAY out of range 0..4");
        end
    endgenerate

    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [10:0] hc_x;
    logic [10:0] vc_x;
    logic        hs_raw;
    logic        vs_raw;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    assign hc_x  = {1'b0, hc};
    assign vc_x  = {1'b0, vc};
    assign DrawX = hc;
    assign DrawY = vc;

    assign blank       = (hc_x < H_VIS) && (vc_x < V_VIS) && !reset;
    assign line_start  = (hc == 10'd0) && (vc_x < V_VIS) && !reset;
    assign frame_start = (hc == 10'd0) && (vc == 10'd0) && !reset;

    // vs_raw depends only on vc, so its low span covers whole lines starting at hc==0
    assign hs_raw = !((hc_x >= HS_START) && (hc_x < HS_END));
    assign vs_raw = !((vc_x >= VS_START) && (vc_x < VS_END));

    generate
        if (SYNC_DELAY == 0) begin : g_sync_comb
            assign hs = hs_raw | reset;
            assign vs = vs_raw | reset;
        end else begin : g_sync_pipe
            logic [SYNC_DELAY-1:0] hs_pipe;
            logic [SYNC_DELAY-1:0] vs_pipe;

            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    hs_pipe <= '1;
                    vs_pipe <= '1;
                end else begin
                    hs_pipe[0] <= hs_raw;
                    vs_pipe[0] <= vs_raw;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hs_pipe[i] <= hs_pipe[i-1];
                        vs_pipe[i] <= vs_pipe[i-1];
                    end
                end
            end

            assign hs = hs_pipe[SYNC_DELAY-1];
            assign vs = vs_pipe[SYNC_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - randomized-reset bench for vga_scan_gen against a position-arithmetic model
module tb_vga_scan_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic [9:0] dx_a, dy_a, dx_b, dy_b, dx_c, dy_c;
    logic       bl_a, hs_a, vs_a, ls_a, fs_a;
    logic       bl_b, hs_b, vs_b, ls_b, fs_b;
    logic       bl_c, hs_c, vs_c, ls_c, fs_c;

    int vectors = 0;
    int miscompares = 0;

    // H_VIS, H_FP, H_SYNC, H_BP, V_VIS, V_FP, V_SYNC, V_BP, DELAY
    int p_a [9] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    int p_b [9] = '{8, 1, 2, 1, 4, 1, 1, 1, 0};
    int p_c [9] = '{20, 3, 5, 4, 6, 2, 2, 3, 2};

    // cycles since reset release (pixel (0,0) is n=0); -1 while in reset
    int n_a, n_b, n_c;
    int hold_a, hold_b, hold_c;

    vga_scan_gen u_a (
        .vga_clk(clk), .reset(rst_a), .DrawX(dx_a), .DrawY(dy_a), .blank(bl_a),
        .hs(hs_a), .vs(vs_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_scan_gen #(
        .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_DELAY(0)
    ) u_b (
        .vga_clk(clk), .reset(rst_b), .DrawX(dx_b), .DrawY(dy_b), .blank(bl_b),
        .hs(hs_b), .vs(vs_b), .line_start(ls_b), .frame_start(fs_b)
    );

    vga_scan_gen #(
        .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_DELAY(2)
    ) u_c (
        .vga_clk(clk), .reset(rst_c), .DrawX(dx_c), .DrawY(dy_c), .blank(bl_c),
        .hs(hs_c), .vs(vs_c), .line_start(ls_c), .frame_start(fs_c)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs derived from raster position = n mod frame size
    task automatic check_inst(input string nm, input int n, input int p [9],
                              input logic [9:0] dx, input logic [9:0] dy,
                              input logic bl, input logic h, input logic v,
                              input logic ls, input logic fs);
        int ht, vt, x, y, m, mx, my;
        logic e_bl, e_h, e_v, e_ls, e_fs;
        ht = p[0] + p[1] + p[2] + p[3];
        vt = p[4] + p[5] + p[6] + p[7];
        if (n < 0) begin
            x = 0; y = 0; e_bl = 0; e_h = 1; e_v = 1; e_ls = 0; e_fs = 0;
        end else begin
            x    = n % ht;
            y    = (n / ht) % vt;
            e_bl = (x < p[0]) && (y < p[4]);
            e_ls = (x == 0) && (y < p[4]);
            e_fs = (x == 0) && (y == 0);
            m    = n - p[8];
            if (m < 0) begin
                e_h = 1; e_v = 1;
            end else begin
                mx  = m % ht;
                my  = (m / ht) % vt;
                e_h = !((mx >= p[0] + p[1]) && (mx < p[0] + p[1] + p[2]));
                e_v = !((my >= p[4] + p[5]) && (my < p[4] + p[5] + p[6]));
            end
        end
        check_val({nm, "_drawx"}, 32'(dx), 32'(x));
        check_val({nm, "_drawy"}, 32'(dy), 32'(y));
        check_val({nm, "_blank"}, 32'(bl), 32'(e_bl));
        check_val({nm, "_hs"}, 32'(h), 32'(e_h));
        check_val({nm, "_vs"}, 32'(v), 32'(e_v));
        check_val({nm, "_line_start"}, 32'(ls), 32'(e_ls));
        check_val({nm, "_frame_start"}, 32'(fs), 32'(e_fs));
    endtask

    task automatic check_all();
        check_inst("a", n_a, p_a, dx_a, dy_a, bl_a, hs_a, vs_a, ls_a, fs_a);
        check_inst("b", n_b, p_b, dx_b, dy_b, bl_b, hs_b, vs_b, ls_b, fs_b);
        check_inst("c", n_c, p_c, dx_c, dy_c, bl_c, hs_c, vs_c, ls_c, fs_c);
    endtask

    // event-level observations over the reset-free phase
    int   last_ls_a = -1, hs_low_a = 0, last_fs_b = -1, vs_low_b = 0, ls_cnt_b = 0;
    int   last_fs_c = -1, vs_low_c = 0;
    logic prev_hs_a = 1, prev_vs_b = 1, prev_vs_c = 1;

    task automatic observe(input int t);
        if (ls_a) begin
            if (last_ls_a >= 0) check_val("a_line_period", 32'(t - last_ls_a), 32'd800);
            last_ls_a = t;
        end
        if (!hs_a && prev_hs_a) begin
            check_val("a_hs_first_x", 32'(dx_a), 32'd657);
            hs_low_a = 0;
        end
        if (!hs_a) hs_low_a++;
        if (hs_a && !prev_hs_a) check_val("a_hs_width", 32'(hs_low_a), 32'd96);
        prev_hs_a = hs_a;

        if (fs_b) begin
            if (last_fs_b >= 0) begin
                check_val("b_frame_period", 32'(t - last_fs_b), 32'd84);
                check_val("b_lines_per_frame", 32'(ls_cnt_b), 32'd4);
            end
            last_fs_b = t;
            ls_cnt_b  = 0;
        end
        if (ls_b) ls_cnt_b++;
        if (!vs_b && prev_vs_b) begin
            check_val("b_vs_first_y", 32'(dy_b), 32'd5);
            check_val("b_vs_first_x", 32'(dx_b), 32'd0);
            vs_low_b = 0;
        end
        if (!vs_b) vs_low_b++;
        if (vs_b && !prev_vs_b) check_val("b_vs_width", 32'(vs_low_b), 32'd12);
        prev_vs_b = vs_b;

        if (fs_c) begin
            if (last_fs_c >= 0) check_val("c_frame_period", 32'(t - last_fs_c), 32'd416);
            last_fs_c = t;
        end
        if (!vs_c && prev_vs_c) begin
            check_val("c_vs_first_y", 32'(dy_c), 32'd8);
            check_val("c_vs_first_x", 32'(dx_c), 32'd2);
            vs_low_c = 0;
        end
        if (!vs_c) vs_low_c++;
        if (vs_c && !prev_vs_c) check_val("c_vs_width", 32'(vs_low_c), 32'd64);
        prev_vs_c = vs_c;
    endtask

    initial begin
        logic hit_a, hit_b, hit_c, released;
        rst_a = 1; rst_b = 1; rst_c = 1;
        n_a = -1; n_b = -1; n_c = -1;
        hold_a = 0; hold_b = 0; hold_c = 0;

        repeat (5) begin
            @(negedge clk);
            check_all();
        end
        rst_a = 0; rst_b = 0; rst_c = 0;
        n_a = 0; n_b = 0; n_c = 0;
        #1 check_all();

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(posedge clk);
            if (n_a >= 0) n_a++;
            if (n_b >= 0) n_b++;
            if (n_c >= 0) n_c++;

            // asynchronous assertion part-way through the high phase
            hit_a = (cyc >= 2000) && !rst_a && ($urandom_range(0, 999) == 0);
            hit_b = (cyc >= 2000) && !rst_b && ($urandom_range(0, 149) == 0);
            hit_c = (cyc >= 2000) && !rst_c && ($urandom_range(0, 299) == 0);
            if (hit_a || hit_b || hit_c) begin
                #2;
                if (hit_a) begin rst_a = 1; n_a = -1; hold_a = $urandom_range(1, 4); end
                if (hit_b) begin rst_b = 1; n_b = -1; hold_b = $urandom_range(1, 4); end
                if (hit_c) begin rst_c = 1; n_c = -1; hold_c = $urandom_range(1, 4); end
                #1 check_all();
            end

            @(negedge clk);
            check_all();
            if (cyc < 2000) observe(cyc);

            released = 0;
            if (rst_a && cyc >= 2000) begin
                hold_a--;
                if (hold_a <= 0) begin rst_a = 0; n_a = 0; released = 1; end
            end
            if (rst_b && cyc >= 2000) begin
                hold_b--;
                if (hold_b <= 0) begin rst_b = 0; n_b = 0; released = 1; end
            end
            if (rst_c && cyc >= 2000) begin
                hold_c--;
                if (hold_c <= 0) begin rst_c = 0; n_c = 0; released = 1; end
            end
            if (released) #1 check_all();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
